// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner game controller.
// Holds the state encoding, coordinate/velocity widths and the default
// playfield constants used by dino_game_ctrl and dino_score_cnt.
package dino_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned VEL_W   = 6;
    localparam int unsigned SCORE_W = 14;

    localparam int unsigned GROUND_Y_DEF  = 400;
    localparam int unsigned SCREEN_W_DEF  = 640;
    localparam int unsigned SCORE_MAX_DEF = 9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_JUMP = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

endpackage

// File: rtl/dino_score_cnt.sv
// Frame divider plus saturating score counter.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clear   - zero both divider and score (start of a new run)
//   advance - one counted frame; every SCORE_DIV advances bump the score
//   score   - registered binary score, saturates at SCORE_MAX
module dino_score_cnt
    import dino_pkg::*;
#(
    parameter int unsigned SCORE_DIV = 6,
    parameter int unsigned SCORE_MAX = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

    logic [DIV_W-1:0]   r_div;
    logic [SCORE_W-1:0] r_score;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_div   <= '0;
            r_score <= '0;
        end else if (advance) begin
            if (r_div == DIV_W'(SCORE_DIV - 1)) begin
                // Divider keeps cycling after the score has saturated.
                r_div <= '0;
                if (r_score != SCORE_W'(SCORE_MAX)) begin
                    r_score <= r_score + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign score = r_score;

endmodule

// File: rtl/dino_game_ctrl.sv
// Per-frame game sequencer for the dino runner: jump physics, ground scroll,
// score and collision handling through IDLE/RUN/JUMP/DEAD.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   frame_tick - one-cycle pulse per frame; gates all per-frame updates
//   jump       - one-cycle button pulse
//   hit        - dino/obstacle pixel overlap at the current pixel
//   dino_y     - dino top y (registered)
//   ground_x   - ground scroll offset 0..SCREEN_W-1 (registered)
//   score      - binary score 0..SCORE_MAX (registered)
//   state      - IDLE=0 RUN=1 JUMP=2 DEAD=3 (registered)
//   dead       - high in DEAD (registered)
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned GROUND_Y     = GROUND_Y_DEF,
    parameter int unsigned JUMP_V0      = 16,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned SCROLL_SPEED = 4,
    parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
    parameter int unsigned SCORE_DIV    = 6,
    parameter int unsigned SCORE_MAX    = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               jump,
    input  logic               hit,
    output logic [COORD_W-1:0] dino_y,
    output logic [COORD_W-1:0] ground_x,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state,
    output logic               dead
);

    state_t                    r_state, w_state_nxt;
    logic [COORD_W-1:0]        r_dino_y, w_dino_y_nxt;
    logic [COORD_W-1:0]        r_ground_x, w_ground_x_nxt;
    logic signed [VEL_W-1:0]   r_vel, w_vel_nxt;
    logic                      r_jump_pend, w_jump_pend_nxt;
    logic                      r_hit_sticky, w_hit_sticky_nxt;
    logic                      r_dead, w_dead_nxt;

    logic                      w_active;
    logic                      w_collide;
    logic                      w_score_clr;
    logic                      w_score_adv;
    logic [COORD_W:0]          w_gx_sum;
    logic signed [COORD_W:0]   w_vel_ext;
    logic signed [COORD_W:0]   w_y_next;
    logic [SCORE_W-1:0]        w_score;

    assign w_active  = (r_state == ST_RUN) || (r_state == ST_JUMP);
    // A hit anywhere in the frame (latched) or on the tick cycle itself counts.
    assign w_collide = w_active && frame_tick && (r_hit_sticky || hit);
    assign w_gx_sum  = {1'b0, r_ground_x} + (COORD_W+1)'(SCROLL_SPEED);
    assign w_vel_ext = {{(COORD_W+1-VEL_W){r_vel[VEL_W-1]}}, r_vel};
    assign w_y_next  = $signed({1'b0, r_dino_y}) - w_vel_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dino_y     <= COORD_W'(GROUND_Y);
            r_ground_x   <= '0;
            r_vel        <= '0;
            r_jump_pend  <= 1'b0;
            r_hit_sticky <= 1'b0;
            r_dead       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dino_y     <= w_dino_y_nxt;
            r_ground_x   <= w_ground_x_nxt;
            r_vel        <= w_vel_nxt;
            r_jump_pend  <= w_jump_pend_nxt;
            r_hit_sticky <= w_hit_sticky_nxt;
            r_dead       <= w_dead_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_dino_y_nxt     = r_dino_y;
        w_ground_x_nxt   = r_ground_x;
        w_vel_nxt        = r_vel;
        w_jump_pend_nxt  = r_jump_pend;
        w_hit_sticky_nxt = (w_active && !frame_tick) ? (r_hit_sticky || hit) : 1'b0;
        w_score_clr      = 1'b0;
        w_score_adv      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (jump) begin
                    w_state_nxt    = ST_RUN;
                    w_ground_x_nxt = '0;
                    w_score_clr    = 1'b1;
                end
            end
            ST_RUN, ST_JUMP: begin
                if (frame_tick) begin
                    if (w_collide) begin
                        w_state_nxt     = ST_DEAD;
                        w_jump_pend_nxt = 1'b0;
                    end else begin
                        w_ground_x_nxt = COORD_W'((w_gx_sum >= (COORD_W+1)'(SCREEN_W)) ?
                                                  (w_gx_sum - (COORD_W+1)'(SCREEN_W)) : w_gx_sum);
                        w_score_adv    = 1'b1;
                        if (r_state == ST_RUN) begin
                            if (r_jump_pend || jump) begin
                                w_state_nxt     = ST_JUMP;
                                w_vel_nxt       = $signed(VEL_W'(JUMP_V0));
                                w_jump_pend_nxt = 1'b0;
                            end
                        end else if ((r_vel < 0) &&
                                     (w_y_next >= $signed((COORD_W+1)'(GROUND_Y)))) begin
                            w_state_nxt  = ST_RUN;
                            w_dino_y_nxt = COORD_W'(GROUND_Y);
                            w_vel_nxt    = '0;
                        end else begin
                            w_dino_y_nxt = COORD_W'(w_y_next);
                            w_vel_nxt    = r_vel - $signed(VEL_W'(GRAVITY));
                        end
                    end
                end else if ((r_state == ST_RUN) && jump) begin
                    w_jump_pend_nxt = 1'b1;
                end
            end
            ST_DEAD: begin
                if (jump) begin
                    w_state_nxt  = ST_IDLE;
                    w_dino_y_nxt = COORD_W'(GROUND_Y);
                    w_vel_nxt    = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_dead_nxt = (w_state_nxt == ST_DEAD);
    end

    dino_score_cnt #(
        .SCORE_DIV (SCORE_DIV),
        .SCORE_MAX (SCORE_MAX)
    ) u_score (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_score_clr),
        .advance (w_score_adv),
        .score   (w_score)
    );

    assign dino_y   = r_dino_y;
    assign ground_x = r_ground_x;
    assign score    = w_score;
    assign state    = r_state;
    assign dead     = r_dead;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl: directed vector table, hand-written
// corner sequences, randomized stimulus against an integer game model, and a
// score-saturation run on a second instance with a one-frame score divider.
module tb_dino_game_ctrl;

    localparam int GY = 400;
    localparam int V0 = 16;
    localparam int G  = 1;
    localparam int SS = 4;
    localparam int SW = 640;
    localparam int SD = 6;
    localparam int SM = 9999;

    logic        clk = 1'b0;
    logic        rst, frame_tick, jump, hit;
    logic [9:0]  dino_y, ground_x;
    logic [13:0] score;
    logic [1:0]  state;
    logic        dead;

    logic        rst2, ft2, jp2, ht2;
    logic [9:0]  dino_y2, ground_x2;
    logic [13:0] score2;
    logic [1:0]  state2;
    logic        dead2;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state (plain integers).
    int m_state, m_y, m_gx, m_frames, m_jt;
    bit m_pend, m_sticky;

    always #5 clk = ~clk;

    dino_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .jump(jump), .hit(hit),
        .dino_y(dino_y), .ground_x(ground_x), .score(score), .state(state), .dead(dead)
    );

    dino_game_ctrl #(.SCORE_DIV(1)) dut_s (
        .clk(clk), .rst(rst2), .frame_tick(ft2), .jump(jp2), .hit(ht2),
        .dino_y(dino_y2), .ground_x(ground_x2), .score(score2), .state(state2), .dead(dead2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_score();
        int s;
        s = m_frames / SD;
        return (s > SM) ? SM : s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_y = GY; m_gx = 0; m_frames = 0; m_jt = 0;
        m_pend = 0; m_sticky = 0;
    endtask

    // Game rules at frame level; the jump arc uses the closed-form height
    // after k airborne ticks: k*V0 - G*k*(k-1)/2.
    task automatic model_step(input bit r, input bit ft, input bit jp, input bit ht);
        bit active, coll;
        int k, v, h;
        if (r) begin
            model_reset();
            return;
        end
        active = (m_state == 1) || (m_state == 2);
        coll   = active && ft && (m_sticky || ht);
        case (m_state)
            0: if (jp) begin m_state = 1; m_gx = 0; m_frames = 0; m_pend = 0; end
            1, 2: begin
                if (ft) begin
                    if (coll) begin
                        m_state = 3; m_pend = 0;
                    end else begin
                        m_gx = (m_gx + SS) % SW;
                        m_frames++;
                        if (m_state == 1) begin
                            if (m_pend || jp) begin m_state = 2; m_jt = 0; m_pend = 0; end
                        end else begin
                            k = m_jt + 1;
                            v = V0 - G * (k - 1);
                            h = k * V0 - G * k * (k - 1) / 2;
                            if (v < 0 && h <= 0) begin
                                m_state = 1; m_y = GY;
                            end else begin
                                m_y = GY - h;
                            end
                            m_jt = k;
                        end
                    end
                end else if (m_state == 1 && jp) begin
                    m_pend = 1;
                end
            end
            default: if (jp) begin m_state = 0; m_y = GY; end
        endcase
        m_sticky = (active && !ft) ? (m_sticky || ht) : 1'b0;
        if (m_state == 0 || m_state == 3) m_sticky = 0;
    endtask

    task automatic cycle(input bit r, input bit ft, input bit jp, input bit ht);
        rst = r; frame_tick = ft; jump = jp; hit = ht;
        model_step(r, ft, jp, ht);
        @(posedge clk);
        #1;
        rst = 0; frame_tick = 0; jump = 0; hit = 0;
    endtask

    task automatic tick();
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    task automatic chk_all(input string tag, input int st, input int y, input int gx,
                           input int sc, input int dd);
        chk({tag, ".state"},    int'(state),    st);
        chk({tag, ".dino_y"},   int'(dino_y),   y);
        chk({tag, ".ground_x"}, int'(ground_x), gx);
        chk({tag, ".score"},    int'(score),    sc);
        chk({tag, ".dead"},     int'(dead),     dd);
    endtask

    typedef struct {
        int n_ticks;
        bit do_jump;
        bit do_hit;
        int e_state;
        int e_y;
        int e_gx;
        int e_sc;
        int e_dead;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{5,   0, 0, 0, 400, 0,   0,  0};  // idle frozen
        vecs[1] = '{161, 1, 0, 1, 400, 4,   26, 0};  // start run, wrap once
        vecs[2] = '{17,  1, 0, 2, 264, 72,  29, 0};  // reach peak
        vecs[3] = '{16,  0, 0, 2, 384, 136, 32, 0};  // 32nd airborne tick
        vecs[4] = '{1,   0, 0, 1, 400, 140, 32, 0};  // lands on 33rd
        vecs[5] = '{10,  1, 0, 2, 292, 180, 34, 0};  // mid-jump
        vecs[6] = '{1,   0, 1, 3, 292, 180, 34, 1};  // latched hit kills
        vecs[7] = '{5,   0, 0, 3, 292, 180, 34, 1};  // dead frozen
        vecs[8] = '{0,   1, 0, 0, 400, 180, 34, 0};  // back to idle
        vecs[9] = '{0,   1, 0, 1, 400, 0,   0,  0};  // new run clears

        rst = 1; frame_tick = 0; jump = 0; hit = 0;
        rst2 = 1; ft2 = 0; jp2 = 0; ht2 = 0;
        model_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk_all("reset", 0, GY, 0, 0, 0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_jump) cycle(0, 0, 1, 0);
            if (vecs[i].do_hit)  cycle(0, 0, 0, 1);
            for (int t = 0; t < vecs[i].n_ticks; t++) tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_y,
                    vecs[i].e_gx, vecs[i].e_sc, vecs[i].e_dead);
        end

        // jump and frame_tick together in RUN: jump takes effect that tick.
        cycle(0, 1, 1, 0);
        chk_all("jump_on_tick", 2, GY, 4, 0, 0);
        tick();
        chk_all("first_rise", 2, GY - V0, 8, 0, 0);
        cycle(0, 0, 1, 0);   // ignored while airborne
        tick();
        chk("air_jump_ignored.y", int'(dino_y), GY - V0 - (V0 - 1));
        // reset dominates mid-jump
        cycle(1, 1, 1, 1);
        chk_all("rst_midjump", 0, GY, 0, 0, 0);
        // hit on the tick cycle itself
        cycle(0, 0, 1, 0);
        tick();
        cycle(0, 1, 0, 1);
        chk_all("hit_on_tick", 3, GY, 4, 0, 1);
        // hit while idle must not be latched into the next run
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        chk_all("idle_hit_dropped", 1, GY, 4, 0, 0);

        // Randomized run against the model.
        cycle(1, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            bit r, ft, jp, ht;
            r  = ($urandom_range(0, 799) == 0);
            ft = ($urandom_range(0, 2) == 0);
            jp = ($urandom_range(0, 9) == 0);
            ht = ($urandom_range(0, 59) == 0);
            cycle(r, ft, jp, ht);
            n_checks++;
            if (int'(state) != m_state || int'(dino_y) != m_y || int'(ground_x) != m_gx ||
                int'(score) != m_score() || int'(dead) != int'(m_state == 3)) begin
                n_fail++;
                $display("FAIL rand[%0d]: got st=%0d y=%0d gx=%0d sc=%0d dead=%0d expected st=%0d y=%0d gx=%0d sc=%0d dead=%0d",
                         c, state, dino_y, ground_x, score, dead,
                         m_state, m_y, m_gx, m_score(), int'(m_state == 3));
            end
        end

        // Score saturation on the one-frame-divider instance.
        @(posedge clk); #1;
        rst2 = 0; jp2 = 1;
        @(posedge clk); #1;
        jp2 = 0;
        chk("sat.start_state", int'(state2), 1);
        ft2 = 1;
        repeat (9998) begin @(posedge clk); #1; end
        chk("sat.score_9998", int'(score2), 9998);
        repeat (12) begin @(posedge clk); #1; end
        ft2 = 0;
        chk("sat.score_max", int'(score2), SM);
        chk("sat.state", int'(state2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
